reg_bank_ctrl: RTL
==================

// Module: reg_bank_ctrl
// PURPOSE
//  Arbitrates NUM_REQ requesters onto one bank of DEPTH tri-state WIDTH-bit d_register cells (shared Q bus).
//  Sequences each access: write = load strobe, read = output enable + bus capture.
//  Sits between the SRAM front-end ports and the register array; sole driver of every cell's G1_n/G2_n/M/N.
// PARAMETERS
//  NUM_REQ  2  number of requesters, >=2
//  DEPTH    4  number of register cells, 1..2**ADDR_W
//  WIDTH    4  data width per cell
//  ADDR_W   2  address width
// PORTS
//  CLK        in   1                clock, all flops posedge
//  CLR        in   1                async active-high reset; also wired to every cell's CLR
//  req_valid  in   NUM_REQ          request pending, held until accepted
//  req_we     in   NUM_REQ          1=write 0=read
//  req_addr   in   NUM_REQ*ADDR_W   packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*WIDTH    packed write data
//  req_ready  out  NUM_REQ          one-hot accept pulse
//  rsp_valid  out  1                one-cycle completion pulse
//  rsp_id     out  $clog2(NUM_REQ)  index of completed requester
//  rsp_rdata  out  WIDTH            read data; 0 for writes and errors
//  rsp_err    out  1                addr >= DEPTH
//  reg_load_n out  DEPTH            per-cell load enable, active low (to G1_n and G2_n)
//  reg_oe_n   out  DEPTH            per-cell output enable, active low (to M; N tied 0)
//  reg_d      out  WIDTH            shared write bus to all cells' D
//  reg_q      in   WIDTH            shared tri-state read bus
//  busy       out  1                state != IDLE
// BEHAVIOUR
//  Reset (CLR=1, async): state=IDLE; rr pointer=0; reg_load_n=all 1; reg_oe_n=all 1; req_ready=0; rsp_valid=0;
//   rsp_id=0; rsp_rdata=0; rsp_err=0; reg_d=0. Reset mid-access aborts the access; no rsp is issued.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: if any req_valid, grant = first valid at or after rr pointer, wrapping.
//   req_ready[grant]=1 this cycle (combinational; no other bit set). Latch id/we/addr/wdata; rr pointer=grant+1 mod NUM_REQ.
//   Next state ACCESS. No valid: stay, all outputs idle.
//  ACCESS, write, addr<DEPTH: reg_load_n[addr]=0, reg_d=wdata; cell loads on the closing posedge.
//  ACCESS, read, addr<DEPTH: reg_oe_n[addr]=0, others 1; reg_q sampled into rdata flop on the closing posedge.
//  ACCESS, addr>=DEPTH: no strobe, no enable; err flop set.
//  DONE: rsp_valid=1 with rsp_id/rsp_rdata/rsp_err from flops; next state IDLE.
//  Latency: accept (IDLE) to rsp_valid = 2 cycles. Throughput: 1 access per 3 cycles under continuous load.
//  Invariants:
//   - reg_load_n and reg_oe_n decode only from state and latched flops; no combinational path from req_*.
//   - At most one reg_oe_n bit low at any time; load and OE never active together.
//   - reg_q is ignored outside ACCESS-read (bus may be Z).
//  A requester dropping valid before ready is legal; no request is recorded.
//  A write followed by a read of the same address returns the new data (write commits before the next IDLE).
// STRUCTURE
//  sram_pkg: state enum {IDLE, ACCESS, DONE}; default WIDTH/ADDR_W constants.
//  Sub-module rr_arbiter (NUM_REQ): valid vector + pointer in, one-hot grant + index out; purely combinational.
//  Top: FSM, latch flops, address decode, response flops.
// TESTING
//  1. Reset, req0 write addr2=0xA, then read addr2:
//     load_n=4'b1011 for one cycle; read rsp_rdata=0xA, rsp_id=0, 2 cycles after accept.
//  2. req0 and req1 valid together, 4 reads each:
//     grants alternate 0,1,0,1...; each req_ready arrives 3 cycles after the previous one.
//  3. Read addr1 with the cell preloaded 0x5:
//     only reg_oe_n[1]=0, during ACCESS only; rsp_rdata=0x5; load_n stays all 1.
//  4. DEPTH=3, write addr3=0xF:
//     no load strobe, rsp_err=1, rsp_rdata=0; a later read of addrs 0..2 is unchanged.
//  5. CLR pulsed during ACCESS-write:
//     load_n returns to all 1 immediately, no rsp_valid, state=IDLE, next grant goes to req0.
//  6. Random req traffic, 1000 ops, with a reference array model:
//     read data matches the model; one-hot OE holds every cycle; no requester is starved (>2 grants apart).

Source files
------------

// File: rtl/reg_bank_ctrl_pkg.sv
// Shared types and default widths for the register-bank controller slice.
package reg_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_ADDR_W = 2;

endpackage

// File: rtl/reg_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, wrapping.
module reg_bank_ctrl_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // Wraparound search as two passes: indices >= ptr first, then indices below ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && valid[i] && (ID_W'(i) >= ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && valid[i] && (ID_W'(i) < ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Arbitrates requesters onto a bank of tri-state register cells sharing one Q bus;
// each access runs IDLE (accept) -> ACCESS (strobe/enable) -> DONE (response).
module reg_bank_ctrl
  import reg_bank_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       rsp_err,
  output logic [DEPTH-1:0]           reg_load_n,
  output logic [DEPTH-1:0]           reg_oe_n,
  output logic [WIDTH-1:0]           reg_d,
  input  logic [WIDTH-1:0]           reg_q,
  output logic                       busy
);

  localparam int unsigned     ID_W    = $clog2(NUM_REQ);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nx;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx, rr_ptr;
  logic                grant_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic [ID_W-1:0]     lat_id;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [WIDTH-1:0]    lat_wdata;
  logic [WIDTH-1:0]    rdata_q;
  logic                err_q;
  logic                addr_ok;

  reg_bank_ctrl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign addr_ok = ({1'b0, lat_addr} < DEPTH_L);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rr_ptr    <= '0;
      lat_id    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        lat_id    <= grant_idx;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == ACCESS) begin
        err_q   <= !addr_ok;
        rdata_q <= (!lat_we && addr_ok) ? reg_q : '0;
      end
    end
  end

  // Cell strobes decode only from state and latched request, so req_* never reaches the bank.
  always_comb begin
    req_ready  = '0;
    reg_load_n = '1;
    reg_oe_n   = '1;
    reg_d      = '0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: req_ready = grant;
      ACCESS: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (lat_addr == ADDR_W'(i)) begin
            if (lat_we) begin
              reg_load_n[i] = 1'b0;
              reg_d         = lat_wdata;
            end else begin
              reg_oe_n[i] = 1'b0;
            end
          end
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = lat_id;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
